// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, defaults and address check for the data RAM arbiter
// Purpose: FSM state encoding, default RAM placement and the legal-address test.
// Contents:
//   state_t     IDLE / BUSY / ACK transaction phases (2'd3 is unused and decodes to IDLE)
//   DMEM_BASE   byte address of RAM word 0
//   DMEM_DEPTH  RAM size in 32-bit words
//   in_range()  1 when a byte address is word-aligned and inside the RAM window
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BASE  = 32'h1001_0000;
  localparam int unsigned DMEM_DEPTH = 2048;

  // The window end is computed in plain 32-bit arithmetic; the comparison is
  // unsigned, so addresses below base never alias into the window.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth);
    logic [31:0] last_addr;
    last_addr = base + (depth << 2) - 32'd4;
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last_addr);
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-requester round-robin pick, purely combinational
// Purpose: chooses which master wins a free RAM slot.
// Ports:
//   req[1:0]   request from master 1 / master 0
//   last_gnt   master granted most recently
//   gnt_valid  1 when any master requests
//   gnt_sel    winning master (0 or 1); meaningful only with gnt_valid
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  always_comb begin
    gnt_valid = |req;
    gnt_sel   = 1'b0;
    if (req == 2'b11) begin
      // On a tie the master that did not win last time goes first.
      gnt_sel = ~last_gnt;
    end else if (req[1]) begin
      gnt_sel = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter and three-phase access sequencer for the data RAM
// Purpose: shares the single-port data RAM between the CPU (m0) and loader/debug (m1).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mN_req/we/addr/wdata        master request, held stable until mN_ack
//   mN_ack/err/rdata            one-cycle completion pulse, reject flag, read data
//   ram_ena/wena/addr/wdata     RAM control, valid during the BUSY phase
//   ram_rdata                   combinational RAM read data for ram_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE  = DMEM_BASE,
  parameter int unsigned DEPTH = DMEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        ram_ena,
  output logic        ram_wena,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_gnt_q, last_gnt_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        gnt_valid;
  logic        gnt_sel;

  arb_rr2 u_arb (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    we_d       = we_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d    = ST_BUSY;
          sel_d      = gnt_sel;
          last_gnt_d = gnt_sel;
          we_d       = gnt_sel ? m1_we    : m0_we;
          addr_d     = gnt_sel ? m1_addr  : m0_addr;
          wdata_d    = gnt_sel ? m1_wdata : m0_wdata;
          err_d      = ~in_range(gnt_sel ? m1_addr : m0_addr, BASE, 32'(DEPTH));
        end
      end
      ST_BUSY: begin
        state_d = ST_ACK;
        // Writes and rejected reads return zero so stale data never leaks.
        rdata_d = (~we_q & ~err_q) ? ram_rdata : 32'h0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // All outputs decode from registers only, so a reset clears them at once.
  assign ram_ena   = (state_q == ST_BUSY) & ~err_q;
  assign ram_wena  = (state_q == ST_BUSY) & ~err_q & we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign m0_ack   = (state_q == ST_ACK) & ~sel_q;
  assign m1_ack   = (state_q == ST_ACK) &  sel_q;
  assign m0_err   = m0_ack & err_q;
  assign m1_err   = m1_ack & err_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a RAM stand-in and transaction model
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_ena, ram_wena;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM stand-in: synchronous write, asynchronous read.
  logic [31:0] ram [DEPTH];
  logic [31:0] roff;
  logic        rin;
  always_comb begin
    roff      = ram_addr - BASE;
    rin       = (ram_addr >= BASE) && (roff < 32'(4 * DEPTH));
    ram_rdata = rin ? ram[roff[12:2]] : 32'h0;
  end
  always @(posedge clk) if (ram_wena && rin) ram[roff[12:2]] <= ram_wdata;

  int tests = 0, fails = 0;
  int tcyc = 0;
  int wena_cnt = 0;
  always @(posedge clk) tcyc <= tcyc + 1;
  always @(posedge clk) if (ram_wena) wena_cnt <= wena_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A granted transaction owns the RAM in the cycle after its grant edge,
  // answers in the cycle after that, and the next grant is possible 3 edges later.
  logic [31:0] mdl_mem [DEPTH];
  int          cyc = 0, next_ok = 0, busy_edge = -10;
  bit          last = 1'b1, t_sel = 1'b0, t_we = 1'b0, t_err = 1'b0;
  logic [31:0] t_addr = 32'h0, t_wdata = 32'h0, exp_rdata = 32'h0;

  function automatic bit illegal(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (a[1:0] != 2'b00) || (la < longint'(BASE)) ||
           (la > longint'(BASE) + 4 * DEPTH - 4);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; next_ok = 0; busy_edge = -10; last = 1'b1; exp_rdata = 32'h0;
    end else begin
      cyc = cyc + 1;
      if (cyc == busy_edge + 1) begin
        exp_rdata = (t_err || t_we) ? 32'h0 : mdl_mem[word_of(t_addr)];
        if (!t_err && t_we) mdl_mem[word_of(t_addr)] = t_wdata;
      end
      if (cyc >= next_ok && (m0_req || m1_req)) begin
        t_sel     = (m0_req && m1_req) ? !last : m1_req;
        last      = t_sel;
        t_we      = t_sel ? m1_we : m0_we;
        t_addr    = t_sel ? m1_addr : m0_addr;
        t_wdata   = t_sel ? m1_wdata : m0_wdata;
        t_err     = illegal(t_addr);
        busy_edge = cyc;
        next_ok   = cyc + 3;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit c_busy, c_ack;
  always @(negedge clk) begin
    c_busy = rst_n && (cyc == busy_edge);
    c_ack  = rst_n && (cyc == busy_edge + 1);
    check("ram_ena",  ram_ena,  c_busy && !t_err);
    check("ram_wena", ram_wena, c_busy && !t_err && t_we);
    check("m0_ack",   m0_ack,   c_ack && !t_sel);
    check("m1_ack",   m1_ack,   c_ack &&  t_sel);
    check("m0_err",   m0_err,   c_ack && !t_sel && t_err);
    check("m1_err",   m1_err,   c_ack &&  t_sel && t_err);
    check("m0_rdata", m0_rdata, exp_rdata);
    check("m1_rdata", m1_rdata, exp_rdata);
    if (c_busy && !t_err) check("ram_addr", ram_addr, t_addr);
    if (c_busy && !t_err && t_we) check("ram_wdata", ram_wdata, t_wdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input int m, input bit we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    if (m == 0) begin m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
    else        begin m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
  endtask

  task automatic wait_ack(input int m, output bit e, output logic [31:0] rd, output int lat);
    int start;
    bit got;
    start = tcyc; got = 1'b0; e = 1'b0; rd = 32'h0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        e   = (m == 0) ? m0_err : m1_err;
        rd  = (m == 0) ? m0_rdata : m1_rdata;
        lat = tcyc - start;
        break;
      end
    end
    if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic xact(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                      output bit e, output logic [31:0] rd, output int lat);
    issue(m, we, a, d);
    wait_ack(m, e, rd, lat);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] ram_sum();
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < DEPTH; i++) s = s + (ram[i] ^ 32'(i * 7));
    return s;
  endfunction

  bit          e;
  logic [31:0] rd, sum0;
  int          lat, w0;
  int          who [4];
  int          when [4];
  int          nack;
  logic [31:0] bad_addr [3];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = 32'hA500_0000 | 32'(i);
      mdl_mem[i] = 32'hA500_0000 | 32'(i);
    end
    #1 rst_n = 1'b0;
    #2;
    check("rst_ram_ena",   ram_ena,   32'd0);
    check("rst_ram_wena",  ram_wena,  32'd0);
    check("rst_ram_addr",  ram_addr,  32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_m0_ack",    m0_ack,    32'd0);
    check("rst_m1_rdata",  m1_rdata,  32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Write then read on m0.
    xact(0, 1'b1, 32'h1001_0010, 32'hDEAD_BEEF, e, rd, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", e, 32'd0);
    xact(0, 1'b0, 32'h1001_0010, 32'h0, e, rd, lat);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_err", e, 32'd0);
    check("rd_data", rd, 32'hDEAD_BEEF);

    // Tie out of reset, requests held: m0, m1, m0, m1 three cycles apart.
    do_reset();
    @(posedge clk); #2;
    m0_we = 1'b0; m0_addr = 32'h1001_0010; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 32'h1001_0014; m1_req = 1'b1;
    w0 = tcyc; nack = 0;
    for (int i = 0; i < 30 && nack < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        who[nack]  = m1_ack ? 1 : 0;
        when[nack] = tcyc - w0;
        if (nack == 0) check("tie_first_rdata", m0_rdata, 32'hDEAD_BEEF);
        if (nack == 1) check("tie_second_rdata", m1_rdata, 32'hA500_0005);
        nack++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("tie_count", 32'(nack), 32'd4);
    for (int i = 0; i < 4 && i < nack; i++) begin
      check("tie_who",  32'(who[i]),  32'(i % 2));
      check("tie_when", 32'(when[i]), 32'(2 + 3 * i));
    end

    // Rejected writes on m1: above range, below range, misaligned.
    bad_addr[0] = 32'h1001_2000;
    bad_addr[1] = 32'h1000_FFFC;
    bad_addr[2] = 32'h1001_0002;
    sum0 = ram_sum();
    w0   = wena_cnt;
    for (int i = 0; i < 3; i++) begin
      xact(1, 1'b1, bad_addr[i], 32'h0BAD_0000 | 32'(i), e, rd, lat);
      check("oor_err",   e,  32'd1);
      check("oor_rdata", rd, 32'h0);
    end
    check("oor_no_wena", 32'(wena_cnt - w0), 32'd0);
    check("oor_ram_sum", ram_sum(), sum0);

    // Boundary words 0 and DEPTH-1.
    xact(0, 1'b1, 32'h1001_0000, 32'h1234_5678, e, rd, lat);
    check("lo_wr_err", e, 32'd0);
    xact(1, 1'b1, 32'h1001_1FFC, 32'hCAFE_F00D, e, rd, lat);
    check("hi_wr_err", e, 32'd0);
    xact(1, 1'b0, 32'h1001_0000, 32'h0, e, rd, lat);
    check("lo_rd_err", e, 32'd0);
    check("lo_rd_data", rd, 32'h1234_5678);
    xact(0, 1'b0, 32'h1001_1FFC, 32'h0, e, rd, lat);
    check("hi_rd_err", e, 32'd0);
    check("hi_rd_data", rd, 32'hCAFE_F00D);

    // Reset in the middle of a BUSY write.
    issue(0, 1'b1, 32'h1001_0020, 32'h5555_AAAA);
    @(posedge clk); #1;
    check("mid_busy_wena", ram_wena, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wena", ram_wena, 32'd0);
    check("mid_rst_ack",  m0_ack,   32'd0);
    m0_req = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    nack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) nack++;
    end
    check("mid_rst_no_ack", 32'(nack), 32'd0);
    check("mid_rst_lost_write", ram[8], 32'hA500_0008);
    xact(0, 1'b1, 32'h1001_0020, 32'h5555_AAAA, e, rd, lat);
    check("reissue_lat", 32'(lat), 32'd2);
    check("reissue_err", e, 32'd0);
    xact(0, 1'b0, 32'h1001_0020, 32'h0, e, rd, lat);
    check("reissue_rd", rd, 32'h5555_AAAA);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
